// File: rtl/flit_check_sink.sv
// Four-phase req/ack flit sink: checks payloads against an incrementing sequence and counts flits and errors.
// ack rises ACK_DELAY edges after capture and falls on the first edge sampling req low; a new flit is taken only in IDLE.
module flit_check_sink #(
  parameter int SIZE        = 8,
  parameter int max_flits   = 5,
  parameter int START_VALUE = 0,
  parameter int ACK_DELAY   = 0,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  output logic             ack,
  input  logic [SIZE-1:0]  data,
  output logic [CNT_W-1:0] flit_count,
  output logic [CNT_W-1:0] error_count,
  output logic             done,
  output logic             overflow,
  output logic [SIZE-1:0]  last_data
);

  localparam int               DW         = (ACK_DELAY > 2) ? $clog2(ACK_DELAY) : 1;
  localparam logic [DW-1:0]    DELAY_LOAD = DW'((ACK_DELAY > 0) ? ACK_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] MAXF       = CNT_W'(max_flits);
  localparam logic [SIZE-1:0]  START      = SIZE'(START_VALUE);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t           state;
  logic [SIZE-1:0]  expected;
  logic [DW-1:0]    delay;
  logic [CNT_W-1:0] flit_count_nxt;

  assign flit_count_nxt = (flit_count == '1) ? flit_count : flit_count + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ack         <= 1'b0;
      flit_count  <= '0;
      error_count <= '0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      last_data   <= '0;
      expected    <= START;
      delay       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            last_data  <= data;
            flit_count <= flit_count_nxt;
            if (data != expected && error_count != '1)
              error_count <= error_count + 1'b1;
            // expected always advances so a single corrupt flit costs exactly one error
            expected <= expected + 1'b1;
            if (done)
              overflow <= 1'b1;
            if (MAXF != '0 && flit_count_nxt == MAXF)
              done <= 1'b1;
            if (ACK_DELAY == 0) begin
              ack   <= 1'b1;
              state <= ACK;
            end else begin
              delay <= DELAY_LOAD;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (delay == '0) begin
            ack   <= 1'b1;
            state <= ACK;
          end else begin
            delay <= delay - 1'b1;
          end
        end
        ACK: begin
          if (!req) begin
            ack   <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          ack   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flit_check_sink.sv
// Directed bench: four sink instances (default, START=FE, ACK_DELAY=3, max_flits=2) share one req/data source.
module tb_flit_check_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [7:0]  data;
  logic        ack [4];
  logic [15:0] fc  [4];
  logic [15:0] ec  [4];
  logic        dn  [4];
  logic        ov  [4];
  logic [7:0]  ld  [4];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  flit_check_sink #(.SIZE(8), .max_flits(5), .START_VALUE(0), .ACK_DELAY(0), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .req(req), .ack(ack[0]), .data(data), .flit_count(fc[0]),
    .error_count(ec[0]), .done(dn[0]), .overflow(ov[0]), .last_data(ld[0]));
  flit_check_sink #(.SIZE(8), .max_flits(5), .START_VALUE('hFE), .ACK_DELAY(0), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .req(req), .ack(ack[1]), .data(data), .flit_count(fc[1]),
    .error_count(ec[1]), .done(dn[1]), .overflow(ov[1]), .last_data(ld[1]));
  flit_check_sink #(.SIZE(8), .max_flits(5), .START_VALUE(0), .ACK_DELAY(3), .CNT_W(16)) u2 (
    .clk(clk), .reset(reset), .req(req), .ack(ack[2]), .data(data), .flit_count(fc[2]),
    .error_count(ec[2]), .done(dn[2]), .overflow(ov[2]), .last_data(ld[2]));
  flit_check_sink #(.SIZE(8), .max_flits(2), .START_VALUE(0), .ACK_DELAY(0), .CNT_W(16)) u3 (
    .clk(clk), .reset(reset), .req(req), .ack(ack[3]), .data(data), .flit_count(fc[3]),
    .error_count(ec[3]), .done(dn[3]), .overflow(ov[3]), .last_data(ld[3]));

  // Full four-phase handshake paced by instance sel; ends at a negedge with req and ack low.
  task automatic send_flit(input int sel, input logic [7:0] d);
    int n;
    @(negedge clk);
    req  = 1'b1;
    data = d;
    n = 0;
    do begin @(negedge clk); n++; end while (ack[sel] !== 1'b1 && n < 20);
    tests++;
    if (ack[sel] !== 1'b1) begin
      fails++;
      $display("FAIL handshake_ack_rise inst%0d data=%h: ack=%b required 1", sel, d, ack[sel]);
    end
    req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (ack[sel] !== 1'b0 && n < 20);
    tests++;
    if (ack[sel] !== 1'b0) begin
      fails++;
      $display("FAIL handshake_ack_fall inst%0d data=%h: ack=%b required 0", sel, d, ack[sel]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = 1'b0;
    data  = 8'h00;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 1'b0;
    data  = 8'h00;
    #13;
    tests++;
    if (ack[0] !== 1'b0 || fc[0] !== 16'd0 || ec[0] !== 16'd0) begin
      fails++;
      $display("FAIL reset_counts: ack=%b fc=%0d ec=%0d required 0 0 0", ack[0], fc[0], ec[0]);
    end
    tests++;
    if (dn[0] !== 1'b0 || ov[0] !== 1'b0 || ld[0] !== 8'h00) begin
      fails++;
      $display("FAIL reset_flags: done=%b ovf=%b last=%h required 0 0 00", dn[0], ov[0], ld[0]);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_sequence();
    do_reset();
    for (int i = 0; i < 4; i++) send_flit(0, 8'(i));
    tests++;
    if (dn[0] !== 1'b0) begin
      fails++;
      $display("FAIL seq_done_early: done=%b required 0 after 4 flits", dn[0]);
    end
    send_flit(0, 8'h04);
    tests++;
    if (fc[0] !== 16'd5 || ec[0] !== 16'd0) begin
      fails++;
      $display("FAIL seq_counts: fc=%0d ec=%0d required 5 0", fc[0], ec[0]);
    end
    tests++;
    if (dn[0] !== 1'b1 || ov[0] !== 1'b0 || ld[0] !== 8'h04) begin
      fails++;
      $display("FAIL seq_flags: done=%b ovf=%b last=%h required 1 0 04", dn[0], ov[0], ld[0]);
    end
  endtask

  task automatic test_error();
    do_reset();
    send_flit(0, 8'h00);
    send_flit(0, 8'h01);
    tests++;
    if (ec[0] !== 16'd0) begin
      fails++;
      $display("FAIL err_before_bad: ec=%0d required 0", ec[0]);
    end
    send_flit(0, 8'h07);
    send_flit(0, 8'h03);
    tests++;
    if (ec[0] !== 16'd1 || fc[0] !== 16'd4 || ld[0] !== 8'h03) begin
      fails++;
      $display("FAIL err_counts: ec=%0d fc=%0d last=%h required 1 4 03", ec[0], fc[0], ld[0]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    send_flit(1, 8'hFE);
    send_flit(1, 8'hFF);
    send_flit(1, 8'h00);
    tests++;
    if (ec[1] !== 16'd0 || fc[1] !== 16'd3 || ld[1] !== 8'h00) begin
      fails++;
      $display("FAIL wrap_counts: ec=%0d fc=%0d last=%h required 0 3 00", ec[1], fc[1], ld[1]);
    end
    // the START=0 instance saw the same flits, none of which matched 00,01,02
    tests++;
    if (ec[0] !== 16'd3) begin
      fails++;
      $display("FAIL wrap_other_inst: ec=%0d required 3", ec[0]);
    end
  endtask

  task automatic test_ack_delay();
    logic exp_ack [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    req  = 1'b1;
    data = 8'h00;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests++;
      if (ack[2] !== exp_ack[k]) begin
        fails++;
        $display("FAIL ackdly_edge_N+%0d: ack=%b required %b", k, ack[2], exp_ack[k]);
      end
      if (k == 0) begin
        tests++;
        if (fc[2] !== 16'd1) begin
          fails++;
          $display("FAIL ackdly_capture: fc=%0d required 1", fc[2]);
        end
      end
    end
    req = 1'b0;
    @(negedge clk);
    tests++;
    if (ack[2] !== 1'b0) begin
      fails++;
      $display("FAIL ackdly_fall: ack=%b required 0", ack[2]);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    send_flit(3, 8'h00);
    send_flit(3, 8'h01);
    tests++;
    if (dn[3] !== 1'b1 || ov[3] !== 1'b0) begin
      fails++;
      $display("FAIL ovf_after2: done=%b ovf=%b required 1 0", dn[3], ov[3]);
    end
    send_flit(3, 8'h02);
    tests++;
    if (ov[3] !== 1'b1 || dn[3] !== 1'b1 || fc[3] !== 16'd3 || ec[3] !== 16'd0) begin
      fails++;
      $display("FAIL ovf_after3: ovf=%b done=%b fc=%0d ec=%0d required 1 1 3 0", ov[3], dn[3], fc[3], ec[3]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) send_flit(0, 8'(i + 1));
    @(negedge clk);
    req  = 1'b1;
    data = 8'h05;
    @(posedge clk);
    #2;
    tests++;
    if (ack[0] !== 1'b1 || dn[0] !== 1'b1) begin
      fails++;
      $display("FAIL mid_pre: ack=%b done=%b required 1 1", ack[0], dn[0]);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (ack[0] !== 1'b0 || fc[0] !== 16'd0 || ec[0] !== 16'd0 || dn[0] !== 1'b0 || ov[0] !== 1'b0) begin
      fails++;
      $display("FAIL mid_async: ack=%b fc=%0d ec=%0d done=%b ovf=%b required 0 0 0 0 0",
               ack[0], fc[0], ec[0], dn[0], ov[0]);
    end
    @(negedge clk);
    req   = 1'b0;
    reset = 1'b0;
    send_flit(0, 8'h00);
    tests++;
    if (ec[0] !== 16'd0 || fc[0] !== 16'd1 || ld[0] !== 8'h00) begin
      fails++;
      $display("FAIL mid_restart: ec=%0d fc=%0d last=%h required 0 1 00", ec[0], fc[0], ld[0]);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_error();
    test_wrap();
    test_ack_delay();
    test_overflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
